// File: rtl/gf_pkg.sv
// Shared constants and state encoding for the bit-serial GF(2^M) multiplier.
// Defaults describe the AES field x^8 + x^4 + x^3 + x + 1.
package gf_pkg;

    localparam int         GF_M    = 8;
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x in GF(2^M), reduced by the implicit x^M + POLY.
// It has no carries: the shifted-out MSB folds back in as an XOR with POLY.
module gf_xtime #(
    parameter int           M    = 8,
    parameter logic [M-1:0] POLY = 8'h1B
) (
    input  logic [M-1:0] x,
    output logic [M-1:0] y
);

    assign y = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : '0);

endmodule

// File: rtl/gf_serial_mult.sv
// Bit-serial MSB-first GF(2^M) multiplier with valid/ready handshakes on both sides.
// An operand pair is accepted in IDLE, M shift-and-add steps run in RUN, and the result is held in DONE.
module gf_serial_mult
    import gf_pkg::*;
#(
    parameter int           M    = GF_M,
    parameter logic [M-1:0] POLY = M'(GF_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] result,
    output logic         busy
);

    localparam int CW = $clog2(M);

    state_e        state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  acc_x2;

    gf_xtime #(.M(M), .POLY(POLY)) u_xtime (
        .x (acc_q),
        .y (acc_x2)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = CW'(M - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_x2 ^ (b_q[cnt_q] ? a_q : '0);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode registered state only, so none depends combinationally on an input.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = acc_q;

endmodule

// File: doc/gf_serial_mult.md
# gf_serial_mult

Bit-serial GF(2^M) multiplier stage with valid/ready handshakes on both sides. It accepts one operand pair, runs one MSB-first shift-and-add step per clock for M clocks, and holds the reduced product until the downstream stage takes it. It sits between the operand source and the systolic multiplier array. It is also the golden reference stage the array's outputs are checked against.

## Interface
- M, default 8: field degree; operand and result width.
- POLY, default 8'h1B: low M bits of the irreducible polynomial; the x^M term is implicit. The default is x^8+x^4+x^3+x+1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  stage can accept an operand pair.
- a  input  M  multiplicand.
- b  input  M  multiplier, consumed MSB first.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  M  a·b mod (x^M + POLY).
- busy  output  1  high while in RUN or DONE.

## Operation
- FSM states and transitions:
  - IDLE → RUN on in_valid & in_ready.
  - RUN → DONE at the step with cnt == 0.
  - DONE → IDLE on out_valid & out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE). busy = (state != IDLE). All are decoded from registered state only.
- Accept edge: capture a_r = a and b_r = b. Set acc = 0 and cnt = M-1. Enter RUN.
- Each RUN edge computes acc' = xtime(acc) ^ (b_r[cnt] ? a_r : 0), then decrements cnt.
  - xtime(x) = (x << 1) truncated to M bits, XORed with POLY if x[M-1] == 1.
- result is driven from acc at all times. It is stable and meaningful only while out_valid is high.
- DONE holds acc, a_r and b_r unchanged for any number of cycles while out_ready is low.
- in_valid, a and b are ignored outside IDLE. They are not sampled in RUN or DONE.
- No accept happens in the same cycle as the result handoff: in_ready is low in DONE.
- Arithmetic is pure XOR/shift with no carries. cnt is ceil(log2(M)) bits wide, and M ≥ 2 is required.

## Timing
- Reset values: state = IDLE, acc = 0, a_r = 0, b_r = 0, cnt = 0. This gives in_ready = 1, out_valid = 0, busy = 0 and result = 0.
- Reset asserted mid-RUN or mid-DONE immediately forces the reset values. The pending operation is discarded and no out_valid pulse follows.
- Latency: with accept at edge T0, out_valid rises after edge T0+M.
- Earliest next accept: edge T0+M+2. This assumes out_ready is high at edge T0+M+1, which returns the FSM to IDLE.
- Initiation interval is M+2 cycles minimum.
- out_valid never drops without a handshake, except under reset.
- in_ready may be high with in_valid low indefinitely; the stage stays in IDLE.

## Structure
- Package gf_pkg holds:
  - the default M and POLY constants;
  - the state enum {IDLE, RUN, DONE}, encoded as 2 bits.
- One sub-module is natural: gf_xtime, a combinational multiply-by-x with reduction, parameterised by M and POLY. gf_serial_mult instantiates it once on the acc path.
- The datapath is registers a_r, b_r, acc and cnt. Control is a single FSM with no further hierarchy.

## Test plan
- Reset: hold rst low for 3 cycles, then release. Require in_ready = 1, out_valid = 0, busy = 0 and result = 0.
- Known vectors:
  - a = 8'h57, b = 8'h83 → result 8'hC1;
  - a = 8'h57, b = 8'h13 → result 8'hFE;
  - a = 8'h02, b = 8'h80 → result 8'h1B.
  - For each vector, out_valid rises exactly 8 cycles after the accept edge.
- Identities: a = 8'hA5 with b = 8'h01 → 8'hA5. a = 8'hA5 with b = 8'h00 → 8'h00. a = 8'h00 with b = 8'hFF → 8'h00.
- Backpressure: hold out_ready low for 20 cycles after out_valid rises. Require result and out_valid held stable and in_ready = 0, and require that a/b changes in that window have no effect. Then pulse out_ready for 1 cycle and require in_ready = 1 on the next cycle.
- Back-to-back: keep in_valid and out_ready high continuously. Require accepts exactly every 10 cycles and no lost or duplicated results.
- Reset mid-RUN: accept a = 8'h57, b = 8'h83, then assert rst after 4 cycles. Require immediate return to IDLE with result = 0 and no out_valid. A subsequent operation must produce the correct result.
